// File: rtl/flash_rd_ctrl_pkg.sv
// Shared types and constants for the parallel NOR flash read controller.
package flash_rd_ctrl_pkg;

   typedef logic [31:0] word_t;
   typedef logic [15:0] half_t;

   typedef enum logic [2:0] {
      S_RST,
      S_RECOV,
      S_CMD_SETUP,
      S_CMD_WE,
      S_CMD_HOLD,
      S_IDLE,
      S_RD_LO,
      S_RD_HI
   } flash_state_t;

   // Command word that puts the x28fxxxp30 into read-array mode.
   localparam half_t FLASH_CMD_READ_ARRAY = 16'h00FF;

   // Largest of four timing parameters; sizes the shared down-counter.
   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/flash_rd_ctrl_timer.sv
// Loadable down-counter shared by every timed phase of the flash sequencer.
// Counts down to zero and parks there; done is high while the count is zero.
module flash_timer #(
   parameter int              W    = 4,
   parameter logic [W-1:0]    INIT = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] cnt;

   // Load a new interval, otherwise count down and hold at zero.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its inputs from the same edge, independent of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= INIT;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/flash_rd_ctrl.sv
// Read-only sequencer for a 16-bit parallel NOR flash: releases the part from
// reset, writes the read-array command, then serves 32-bit reads as two
// timed halfword accesses (low half first).
module flash_rd_ctrl
   import flash_rd_ctrl_pkg::*;
#(
   parameter int RST_CYCLES     = 8,
   parameter int RECOVER_CYCLES = 16,
   parameter int ACCESS_CYCLES  = 6,
   parameter int WE_CYCLES      = 3,
   parameter int ADDR_W         = 23
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic [ADDR_W-3:0] req_addr,
   output logic              req_ready,
   output word_t             rdata,
   output logic              rdata_valid,
   output logic              init_done,
   output logic [ADDR_W-1:0] flash_a,
   input  half_t             flash_d_i,
   output half_t             flash_d_o,
   output logic              flash_d_oe,
   output logic              flash_ce_n,
   output logic              flash_oe_n,
   output logic              flash_we_n,
   output logic              flash_rp_n,
   output logic              flash_vpen
);

   localparam int CNT_MAX = max4(RST_CYCLES, RECOVER_CYCLES, ACCESS_CYCLES, WE_CYCLES);
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   // Counter load values: an interval of N cycles loads N-1.
   localparam logic [CNT_W-1:0] RST_LD   = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] RECOV_LD = CNT_W'(RECOVER_CYCLES - 1);
   localparam logic [CNT_W-1:0] ACC_LD   = CNT_W'(ACCESS_CYCLES - 1);
   localparam logic [CNT_W-1:0] WE_LD    = CNT_W'(WE_CYCLES - 1);

   flash_state_t      state;
   logic [ADDR_W-3:0] addr_q;
   logic              tmr_load;
   logic [CNT_W-1:0]  tmr_val;
   logic              tmr_done;
   logic              accept;

   // The part is never programmed or erased.
   assign flash_vpen = 1'b0;

   assign accept = (state == S_IDLE) && req_valid && req_ready;

   // Timer starts out loaded with the reset-pulse width.
   flash_timer #(
      .W    (CNT_W),
      .INIT (RST_LD)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   // Reload the shared timer on entry to each timed phase.
   // NOTE: every signal written here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = '0;
      case (state)
         S_RST:       if (tmr_done) begin tmr_load = 1'b1; tmr_val = RECOV_LD; end
         S_CMD_SETUP: begin tmr_load = 1'b1; tmr_val = WE_LD; end
         S_IDLE:      if (accept) begin tmr_load = 1'b1; tmr_val = ACC_LD; end
         S_RD_LO:     if (tmr_done) begin tmr_load = 1'b1; tmr_val = ACC_LD; end
         default:     ;
      endcase
   end

   // Sequencer: reset/recovery, read-array command write, then halfword reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_RST;
         addr_q      <= '0;
         req_ready   <= 1'b0;
         rdata       <= '0;
         rdata_valid <= 1'b0;
         init_done   <= 1'b0;
         flash_a     <= '0;
         flash_d_o   <= '0;
         flash_d_oe  <= 1'b0;
         flash_ce_n  <= 1'b1;
         flash_oe_n  <= 1'b1;
         flash_we_n  <= 1'b1;
         flash_rp_n  <= 1'b0;
      end else begin
         rdata_valid <= 1'b0;
         case (state)
            S_RST: begin
               if (tmr_done) begin
                  flash_rp_n <= 1'b1;
                  state      <= S_RECOV;
               end
            end
            S_RECOV: begin
               if (tmr_done) begin
                  flash_ce_n <= 1'b0;
                  flash_a    <= '0;
                  flash_d_o  <= FLASH_CMD_READ_ARRAY;
                  flash_d_oe <= 1'b1;
                  state      <= S_CMD_SETUP;
               end
            end
            S_CMD_SETUP: begin
               flash_we_n <= 1'b0;
               state      <= S_CMD_WE;
            end
            S_CMD_WE: begin
               if (tmr_done) begin
                  flash_we_n <= 1'b1;
                  state      <= S_CMD_HOLD;
               end
            end
            S_CMD_HOLD: begin
               flash_d_oe <= 1'b0;
               flash_d_o  <= '0;
               flash_ce_n <= 1'b1;
               init_done  <= 1'b1;
               state      <= S_IDLE;
            end
            S_IDLE: begin
               if (accept) begin
                  addr_q     <= req_addr;
                  flash_a    <= {req_addr, 2'b00};
                  flash_ce_n <= 1'b0;
                  flash_oe_n <= 1'b0;
                  req_ready  <= 1'b0;
                  state      <= S_RD_LO;
               end else begin
                  // Ready rises one cycle after entering idle, so a new
                  // request lands the cycle after the rdata_valid pulse.
                  req_ready <= 1'b1;
               end
            end
            S_RD_LO: begin
               if (tmr_done) begin
                  rdata[15:0] <= flash_d_i;
                  flash_a     <= {addr_q, 2'b10};
                  state       <= S_RD_HI;
               end
            end
            S_RD_HI: begin
               if (tmr_done) begin
                  rdata[31:16] <= flash_d_i;
                  flash_ce_n   <= 1'b1;
                  flash_oe_n   <= 1'b1;
                  rdata_valid  <= 1'b1;
                  state        <= S_IDLE;
               end
            end
            default: state <= S_RST;
         endcase
      end
   end

endmodule

// File: tb/tb_flash_rd_ctrl.sv
// Self-checking bench for flash_rd_ctrl: a timed flash pin model plus a
// word-level reference (expected word = two halfwords of the flash image).
module tb_flash_rd_ctrl;

   localparam int ACC  = 6;
   localparam int RSTC = 8;
   localparam int RECC = 16;
   localparam int WEC  = 3;
   localparam int LAT  = 2 * ACC + 1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic [20:0] req_addr;
   logic        req_ready;
   logic [31:0] rdata;
   logic        rdata_valid;
   logic        init_done;
   logic [22:0] flash_a;
   logic [15:0] flash_d_i = 16'h0000;
   logic [15:0] flash_d_o;
   logic        flash_d_oe;
   logic        flash_ce_n;
   logic        flash_oe_n;
   logic        flash_we_n;
   logic        flash_rp_n;
   logic        flash_vpen;

   int errors = 0;
   int checks = 0;

   flash_rd_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_addr    (req_addr),
      .req_ready   (req_ready),
      .rdata       (rdata),
      .rdata_valid (rdata_valid),
      .init_done   (init_done),
      .flash_a     (flash_a),
      .flash_d_i   (flash_d_i),
      .flash_d_o   (flash_d_o),
      .flash_d_oe  (flash_d_oe),
      .flash_ce_n  (flash_ce_n),
      .flash_oe_n  (flash_oe_n),
      .flash_we_n  (flash_we_n),
      .flash_rp_n  (flash_rp_n),
      .flash_vpen  (flash_vpen)
   );

   always #5 clk = ~clk;

   // Flash image: two fixed words from the read scenario, a hash elsewhere.
   function automatic logic [15:0] flash_word(input logic [22:0] a);
      if (a == 23'h000040) return 16'h5678;
      if (a == 23'h000042) return 16'h1234;
      return a[15:0] ^ 16'h3C5A ^ {a[22:16], 9'h0};
   endfunction

   function automatic logic [31:0] exp_word(input logic [20:0] wa);
      return {flash_word({wa, 2'b10}), flash_word({wa, 2'b00})};
   endfunction

   // Pin model: data is valid only once the address has been stable with
   // ce_n/oe_n low for ACC cycles; before that it returns junk.
   logic [22:0] last_a = '0;
   int          age    = 0;
   always @(negedge clk) begin
      if (flash_ce_n || flash_oe_n) age = 0;
      else if (flash_a != last_a)   age = 1;
      else                          age++;
      last_a    = flash_a;
      flash_d_i = (age >= ACC) ? flash_word(flash_a) : 16'hBAD0;
   end

   // Data bus must never be driven while the flash drives it, vpen stays low.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         checks++;
         if ((flash_d_oe && !flash_oe_n) || flash_vpen !== 1'b0) begin
            errors++;
            $display("FAIL bus_conflict: d_oe=%0b oe_n=%0b vpen=%0b expected no overlap, vpen 0",
                     flash_d_oe, flash_oe_n, flash_vpen);
         end
      end
   end

   task automatic wait_accept(input string tag, output bit ok, output int n);
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 400) begin
         @(negedge clk);
         n++;
      end
      ok = req_ready;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s accept_timeout: req_ready=%0b expected 1", tag, req_ready);
      end
   endtask

   task automatic wait_valid(output int k, output logic [22:0] a_lo, output logic [22:0] a_hi);
      k    = 0;
      a_lo = '0;
      a_hi = '0;
      do begin
         @(negedge clk);
         k++;
         if (k == 1)       a_lo = flash_a;
         if (k == ACC + 1) a_hi = flash_a;
      end while (!rdata_valid && k < 100);
   endtask

   task automatic check_init(input string tag);
      int rp_low = 0, we_low = 0, bad_cmd = 0, oe_early = 0, vseen = 0, n = 0;
      while (!init_done && n < 300) begin
         @(negedge clk);
         n++;
         if (!flash_rp_n) rp_low++;
         if (!flash_we_n) begin
            we_low++;
            if (flash_d_o !== 16'h00FF || flash_d_oe !== 1'b1 || flash_ce_n !== 1'b0) bad_cmd++;
         end
         if (!flash_oe_n) oe_early++;
         if (rdata_valid) vseen++;
      end
      checks++;
      if (init_done !== 1'b1) begin errors++; $display("FAIL %s init_done: got %0b expected 1", tag, init_done); end
      checks++;
      if (rp_low != RSTC) begin errors++; $display("FAIL %s rp_low_cycles: got %0d expected %0d", tag, rp_low, RSTC); end
      checks++;
      if (we_low != WEC) begin errors++; $display("FAIL %s we_low_cycles: got %0d expected %0d", tag, we_low, WEC); end
      checks++;
      if (bad_cmd != 0) begin errors++; $display("FAIL %s cmd_bus: %0d bad cycles expected 0", tag, bad_cmd); end
      checks++;
      if (oe_early != 0 || vseen != 0) begin
         errors++;
         $display("FAIL %s init_quiet: oe_low=%0d rdata_valid=%0d expected 0 0", tag, oe_early, vseen);
      end
      checks++;
      if (flash_d_oe !== 1'b0 || flash_ce_n !== 1'b1) begin
         errors++;
         $display("FAIL %s post_init_pins: d_oe=%0b ce_n=%0b expected 0 1", tag, flash_d_oe, flash_ce_n);
      end
   endtask

   task automatic do_read(input logic [20:0] wa, input logic [22:0] exp_lo,
                          input logic [22:0] exp_hi, input string tag);
      bit          ok;
      int          n, k;
      logic [22:0] a_lo, a_hi;
      logic [31:0] exp;
      exp       = exp_word(wa);
      req_addr  = wa;
      req_valid = 1'b1;
      wait_accept(tag, ok, n);
      if (!ok) begin
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_addr  = 21'($urandom);
      wait_valid(k, a_lo, a_hi);
      checks++;
      if (k != LAT) begin errors++; $display("FAIL %s latency: got %0d expected %0d", tag, k, LAT); end
      checks++;
      if (rdata !== exp) begin errors++; $display("FAIL %s rdata: got %h expected %h", tag, rdata, exp); end
      checks++;
      if (a_lo !== exp_lo || a_hi !== exp_hi) begin
         errors++;
         $display("FAIL %s flash_a: got %h/%h expected %h/%h", tag, a_lo, a_hi, exp_lo, exp_hi);
      end
      @(negedge clk);
      checks++;
      if (rdata_valid !== 1'b0 || rdata !== exp) begin
         errors++;
         $display("FAIL %s hold: valid=%0b rdata=%h expected 0 %h", tag, rdata_valid, rdata, exp);
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_addr  = '0;
      #12;
      checks++;
      if ({flash_rp_n, flash_ce_n, flash_oe_n, flash_we_n, flash_d_oe, flash_vpen,
           req_ready, rdata_valid, init_done} !== 9'b0_111_000_00) begin
         errors++;
         $display("FAIL reset_ctrl: rp ce oe we doe vpen rdy vld init=%b%b%b%b%b%b%b%b%b expected 011100000",
                  flash_rp_n, flash_ce_n, flash_oe_n, flash_we_n, flash_d_oe, flash_vpen,
                  req_ready, rdata_valid, init_done);
      end
      checks++;
      if (flash_a !== 23'h0 || flash_d_o !== 16'h0 || rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_data: a=%h d_o=%h rdata=%h expected 0 0 0", flash_a, flash_d_o, rdata);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_init("init");
   endtask

   task automatic test_single_read();
      do_read(21'h000010, 23'h000040, 23'h000042, "single");
      checks++;
      if (rdata !== 32'h12345678) begin
         errors++;
         $display("FAIL single_const: got %h expected 12345678", rdata);
      end
   endtask

   task automatic test_back_to_back();
      bit          ok;
      int          n, k;
      logic [22:0] a_lo, a_hi;
      req_addr  = 21'd0;
      req_valid = 1'b1;
      wait_accept("b2b", ok, n);
      if (!ok) begin
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      req_addr = 21'd1;
      wait_valid(k, a_lo, a_hi);
      checks++;
      if (k != LAT || rdata !== exp_word(21'd0)) begin
         errors++;
         $display("FAIL b2b_first: lat=%0d rdata=%h expected %0d %h", k, rdata, LAT, exp_word(21'd0));
      end
      checks++;
      if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_on_valid: got %0b expected 0", req_ready); end
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after: got %0b expected 1", req_ready); end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      wait_valid(k, a_lo, a_hi);
      checks++;
      if (k != LAT || rdata !== exp_word(21'd1) || a_lo !== 23'h4 || a_hi !== 23'h6) begin
         errors++;
         $display("FAIL b2b_second: lat=%0d rdata=%h a=%h/%h expected %0d %h 4/6",
                  k, rdata, a_lo, a_hi, LAT, exp_word(21'd1));
      end
      @(negedge clk);
   endtask

   task automatic test_init_request();
      bit          ok;
      int          n, k;
      logic [22:0] a_lo, a_hi;
      logic [20:0] wa;
      wa        = 21'($urandom);
      rst_n     = 1'b0;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      req_addr  = wa;
      req_valid = 1'b1;
      rst_n     = 1'b1;
      wait_accept("init_req", ok, n);
      if (!ok) begin
         req_valid = 1'b0;
         return;
      end
      checks++;
      if (init_done !== 1'b1 || n < RSTC + RECC) begin
         errors++;
         $display("FAIL init_req_early: init_done=%0b wait=%0d expected 1 and >=%0d", init_done, n, RSTC + RECC);
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      wait_valid(k, a_lo, a_hi);
      checks++;
      if (k != LAT || rdata !== exp_word(wa)) begin
         errors++;
         $display("FAIL init_req_read: lat=%0d rdata=%h expected %0d %h", k, rdata, LAT, exp_word(wa));
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_read();
      bit          ok;
      int          n;
      logic [20:0] wa;
      wa        = 21'($urandom);
      req_addr  = wa;
      req_valid = 1'b1;
      wait_accept("mid_rst", ok, n);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (ACC + 3) @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (flash_rp_n !== 1'b0 || flash_ce_n !== 1'b1 || flash_oe_n !== 1'b1 || rdata_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_rst_pins: rp=%0b ce=%0b oe=%0b vld=%0b expected 0 1 1 0",
                  flash_rp_n, flash_ce_n, flash_oe_n, rdata_valid);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_init("reinit");
      wa = 21'($urandom);
      do_read(wa, {wa, 2'b00}, {wa, 2'b10}, "after_rst");
   endtask

   task automatic test_top_address();
      do_read(21'h1FFFFF, 23'h7FFFFC, 23'h7FFFFE, "top_addr");
   endtask

   task automatic test_random_reads();
      logic [20:0] wa;
      for (int i = 0; i < 10; i++) begin
         wa = 21'($urandom);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         do_read(wa, {wa, 2'b00}, {wa, 2'b10}, $sformatf("rand%0d", i));
      end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_back_to_back();
      test_top_address();
      test_random_reads();
      test_init_request();
      test_reset_mid_read();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/flash_rd_ctrl.md
Name: flash_rd_ctrl

Overview:
- Read-only sequencer for the board's 16-bit parallel NOR flash (x28fxxxp30 family).
- Releases the flash from reset and puts it into read-array mode.
- Serves 32-bit word reads from the CPU bus by issuing two timed halfword reads, low half first.
- Sits between the bus/MMU flash region and the top-level flash pins. Tri-state of the data bus is resolved at top level.

Parameters:
- RST_CYCLES, 8: cycles flash_rp_n is held low after controller reset.
- RECOVER_CYCLES, 16: cycles after rp_n release before the first command.
- ACCESS_CYCLES, 6: cycles from address/oe assertion to data sample (tACC 100 ns at 50 MHz plus margin); minimum 1.
- WE_CYCLES, 3: cycles flash_we_n is held low for the read-array command write; minimum 1.
- ADDR_W, 23: flash byte-address width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  read request
- req_addr  in  ADDR_W-2  word address
- req_ready  out  1  controller can accept a request this cycle
- rdata  out  32  read data
- rdata_valid  out  1  one-cycle pulse, rdata valid
- init_done  out  1  flash is in read-array mode
- flash_a  out  ADDR_W  byte address; bit0 always 0
- flash_d_i  in  16  data from pins
- flash_d_o  out  16  data to pins
- flash_d_oe  out  1  drive flash_d_o onto pins
- flash_ce_n  out  1  chip enable
- flash_oe_n  out  1  output enable
- flash_we_n  out  1  write enable
- flash_rp_n  out  1  flash reset
- flash_vpen  out  1  program/erase enable; constant 0

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values of outputs:
  - All `*_n` pins 1, except flash_rp_n = 0.
  - flash_d_oe = 0, flash_d_o = 0, flash_a = 0, flash_vpen = 0.
  - req_ready = 0, rdata = 0, rdata_valid = 0, init_done = 0.
- All flash pin outputs and rdata are registered. One shared down-counter is sized to the maximum of the timing parameters.
- State machine:
  - S_RST: rp_n = 0 for RST_CYCLES cycles, then go to S_RECOV with rp_n = 1.
  - S_RECOV: wait RECOVER_CYCLES cycles, then go to S_CMD_SETUP.
  - S_CMD_SETUP (1 cycle): ce_n = 0, flash_a = 0, d_o = 16'h00FF, d_oe = 1, we_n = 1.
  - S_CMD_WE: we_n = 0 for WE_CYCLES cycles, then go to S_CMD_HOLD.
  - S_CMD_HOLD (1 cycle): we_n = 1 with data still driven. Then d_oe = 0, ce_n = 1, init_done = 1, go to S_IDLE.
  - S_IDLE: req_ready = 1. On req_valid && req_ready:
    - latch req_addr;
    - flash_a = {addr, 2'b00};
    - ce_n = 0, oe_n = 0;
    - go to S_RD_LO.
  - S_RD_LO: after ACCESS_CYCLES cycles, latch flash_d_i into rdata[15:0]. Set flash_a = {addr, 2'b10} with ce_n and oe_n still low, then go to S_RD_HI.
  - S_RD_HI: after ACCESS_CYCLES cycles, latch flash_d_i into rdata[31:16]. Set ce_n = 1, oe_n = 1, pulse rdata_valid for 1 cycle, return to S_IDLE.
- Handshake and latency:
  - req_ready is 0 outside S_IDLE and during the acceptance cycle.
  - Requests presented while not ready are ignored, not queued. Requesters hold req_valid until accepted.
  - Latency from acceptance to rdata_valid is 2*ACCESS_CYCLES+1 cycles.
  - rdata holds its value until the next completed read.
  - Back-to-back: a new request can be accepted in the cycle after rdata_valid.
- flash_d_oe is 1 only during the command states S_CMD_SETUP through S_CMD_HOLD, never while oe_n = 0.
- Address wrap: the req_addr maximum maps to the top 4 bytes of the flash space. No carry beyond ADDR_W.
- Reset mid-operation:
  - Any state returns to S_RST immediately (asynchronous).
  - Pins take their reset values.
  - Any in-flight read is dropped with no rdata_valid.
  - Init is redone in full.
- Requests during init (init_done = 0) are not accepted.

Decomposition:
- Shared package cpu_defines:
  - flash state enum type;
  - FLASH_CMD_READ_ARRAY = 16'h00FF;
  - Word_t / Bit_t reuse.
- One natural sub-module: flash_timer. Loadable down-counter with a `done` output, parameterised width; instanced once.

Test Plan:
- Reset release with default parameters: rp_n low exactly 8 cycles; the command write asserts we_n low exactly 3 cycles with flash_d_o = 16'h00FF and d_oe = 1; init_done rises and d_oe is 0 before oe_n first falls.
- Single read, req_addr = 0x000010, flash model with byte 0x40 holding 16'h5678 and byte 0x42 holding 16'h1234: flash_a shows 0x000040 then 0x000042; rdata = 32'h12345678; rdata_valid asserts exactly 13 cycles after acceptance.
- Back-to-back reads at addr 0 and 1 with req_valid held high: the second is accepted the cycle after the first rdata_valid; data is correct for both; no oe_n/d_oe overlap.
- req_valid asserted during init: not accepted until init_done; the read then completes with correct data.
- rst_n pulsed low during S_RD_HI: no rdata_valid; rp_n drops within the same cycle; the full init sequence repeats; a subsequent read is correct.
- Top address req_addr = 21'h1FFFFF: flash_a = 0x7FFFFC then 0x7FFFFE, with no wrap to 0.
